// File: rtl/mux_share_arb_pkg.sv
// Shared types for the round-robin output-channel arbiter.
// Index width helper keeps a 1-bit pointer legal even for degenerate sizes.
package mux_share_arb_pkg;

   typedef enum logic {
      FREE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mux_share_arbiter_if.sv
// Requester-side and consumer-side handshake bundle of the shared output channel.
// slave = the arbiter, master = the producers/consumer surrounding it.
interface mux_share_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int W     = 8
);
   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ*W-1:0] req_data;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ-1:0]   grant;
   logic               out_valid;
   logic [W-1:0]       out_data;
   logic               out_ready;

   modport master (
      output req_valid, req_data, req_last, out_ready,
      input  req_ready, grant, out_valid, out_data
   );

   modport slave (
      input  req_valid, req_data, req_last, out_ready,
      output req_ready, grant, out_valid, out_data
   );
endinterface

// File: rtl/mux_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Zero latency; no state, no backpressure.
module rr_pick
   import mux_share_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   logic [IDX_W-1:0] pos;

   // Scan from the farthest offset down so the closest hit to ptr is written last.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      pos   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         pos = IDX_W'((int'(ptr_i) + k) % N_REQ);
         if (req_i[pos]) begin
            gnt_o      = '0;
            gnt_o[pos] = 1'b1;
            idx_o      = pos;
            any_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin N:1 share of one registered output channel; 1-cycle accept-to-output latency.
// Stalls all requesters while the output register is full and not drained; MUX_SHARE_ARB_LOCK_EN adds burst locking.
module mux_share_arbiter
   import mux_share_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W     = 8
) (
   input logic               clk,
   input logic               rst,
   mux_share_arbiter_if.slave bus
);

   localparam int IDX_W = idx_w(N_REQ);

   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] win_idx;
   logic             any_elig;
   logic             load_en;
   logic             xfer;

   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     out_data_q,  out_data_d;
   logic [IDX_W-1:0] ptr_q,       ptr_d;

`ifdef MUX_SHARE_ARB_LOCK_EN
   arb_state_e       state_q,   state_d;
   logic [IDX_W-1:0] lock_id_q, lock_id_d;

   always_comb begin
      elig = bus.req_valid;
      if (state_q == LOCKED) begin
         elig = bus.req_valid & (N_REQ'(1) << lock_id_q);
      end
   end

   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      case (state_q)
         FREE: begin
            if (xfer && !bus.req_last[win_idx]) begin
               state_d   = LOCKED;
               lock_id_d = win_idx;
            end
         end
         LOCKED: begin
            if (xfer && bus.req_last[win_idx]) begin
               state_d = FREE;
            end
         end
         default: state_d = FREE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FREE;
         lock_id_q <= '0;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
      end
   end
`else
   logic unused_last;

   assign elig        = bus.req_valid;
   assign unused_last = ^bus.req_last;
`endif

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i (elig),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (win_idx),
      .any_o (any_elig)
   );

   // Reset wins over a load, so ready is withheld to keep producers from dropping a beat.
   assign load_en       = !out_valid_q || bus.out_ready;
   assign xfer          = any_elig && load_en && !rst;
   assign bus.grant     = gnt;
   assign bus.req_ready = (load_en && !rst) ? gnt : '0;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      ptr_d       = ptr_q;
      if (load_en) begin
         out_valid_d = xfer;
      end
      if (xfer) begin
         out_data_d = bus.req_data[int'(win_idx) * W +: W];
         ptr_d      = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         ptr_q       <= ptr_d;
      end
   end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Bench for mux_share_arbiter: directed vector table, lock/reset sequences, random run against a reference model.
module tb_mux_share_arbiter;

   localparam int N = 4;
   localparam int W = 8;
`ifdef MUX_SHARE_ARB_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mux_share_arbiter_if #(.N_REQ(N), .W(W)) bus ();

   mux_share_arbiter #(.N_REQ(N), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit         m_ov;
   logic [7:0] m_od;
   int         m_ptr;
   bit         m_lk;
   int         m_lid;

   typedef struct {
      logic       rst;
      logic [3:0] v;
      logic       ordy;
      logic [3:0] g;
      logic [3:0] rdy;
      logic       ov;
      logic [7:0] od;
   } vec_t;

   vec_t tbl[18];

   function automatic int pick(input logic [N-1:0] v);
      for (int k = 0; k < N; k++) begin
         int i = (m_ptr + k) % N;
         if (v[i] && (!m_lk || i == m_lid)) return i;
      end
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t: got %0h, want %0h", nm, $time, act, exp);
      end
   endtask

   task automatic check_model();
      int w;
      logic [N-1:0] eg, er;
      w  = pick(bus.req_valid);
      eg = (w < 0) ? '0 : (N'(1) << w);
      er = (rst || !(!m_ov || bus.out_ready)) ? '0 : eg;
      chk("m_grant", 32'(bus.grant), 32'(eg));
      chk("m_req_ready", 32'(bus.req_ready), 32'(er));
      chk("m_out_valid", 32'(bus.out_valid), 32'(m_ov));
      chk("m_out_data", 32'(bus.out_data), 32'(m_od));
   endtask

   task automatic model_step();
      int w;
      if (rst) begin
         m_ov = 0; m_od = '0; m_ptr = 0; m_lk = 0; m_lid = 0;
      end else if (!m_ov || bus.out_ready) begin
         w = pick(bus.req_valid);
         if (w >= 0) begin
            m_od  = bus.req_data[w*W +: W];
            m_ov  = 1;
            m_ptr = (w + 1) % N;
            if (LOCK) begin
               if (!m_lk && !bus.req_last[w]) begin
                  m_lk = 1; m_lid = w;
               end else if (m_lk && bus.req_last[w]) begin
                  m_lk = 0;
               end
            end
         end else begin
            m_ov = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic apply(input logic r, input logic [N-1:0] v, input logic [N-1:0] l, input logic ordy);
      rst           = r;
      bus.req_valid = v;
      bus.req_last  = l;
      bus.out_ready = ordy;
      #4;
   endtask

   logic [3:0] lock_exp[4];
   logic [3:0] lock_last[4];
   logic [3:0] lock_v[4];

   initial begin
      tbl[0]  = '{1'b1, 4'hF, 1'b1, 4'h1, 4'h0, 1'b0, 8'h00};
      tbl[1]  = '{1'b1, 4'hF, 1'b1, 4'h1, 4'h0, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 4'hF, 1'b1, 4'h1, 4'h1, 1'b0, 8'h00};
      tbl[3]  = '{1'b0, 4'hF, 1'b1, 4'h2, 4'h2, 1'b1, 8'hA0};
      tbl[4]  = '{1'b0, 4'hF, 1'b1, 4'h4, 4'h4, 1'b1, 8'hA1};
      tbl[5]  = '{1'b0, 4'hF, 1'b1, 4'h8, 4'h8, 1'b1, 8'hA2};
      tbl[6]  = '{1'b0, 4'hF, 1'b1, 4'h1, 4'h1, 1'b1, 8'hA3};
      tbl[7]  = '{1'b0, 4'hF, 1'b0, 4'h2, 4'h0, 1'b1, 8'hA0};
      tbl[8]  = '{1'b0, 4'hF, 1'b0, 4'h2, 4'h0, 1'b1, 8'hA0};
      tbl[9]  = '{1'b0, 4'hF, 1'b0, 4'h2, 4'h0, 1'b1, 8'hA0};
      tbl[10] = '{1'b0, 4'hF, 1'b1, 4'h2, 4'h2, 1'b1, 8'hA0};
      tbl[11] = '{1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b1, 8'hA1};
      tbl[12] = '{1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'hA1};
      tbl[13] = '{1'b1, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'hA1};
      tbl[14] = '{1'b0, 4'h4, 1'b1, 4'h4, 4'h4, 1'b0, 8'h00};
      tbl[15] = '{1'b0, 4'h6, 1'b1, 4'h2, 4'h2, 1'b1, 8'hA2};
      tbl[16] = '{1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b1, 8'hA1};
      tbl[17] = '{1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'hA1};

      m_ov = 0; m_od = '0; m_ptr = 0; m_lk = 0; m_lid = 0;
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_last  = '1;
      bus.req_data  = 32'hA3A2A1A0;
      bus.out_ready = 1'b1;
      tick();

      // Directed table: reset, full contention, backpressure, sparse wrap
      for (int r = 0; r < 18; r++) begin
         apply(tbl[r].rst, tbl[r].v, 4'hF, tbl[r].ordy);
         chk($sformatf("tbl%0d_grant", r), 32'(bus.grant), 32'(tbl[r].g));
         chk($sformatf("tbl%0d_req_ready", r), 32'(bus.req_ready), 32'(tbl[r].rdy));
         chk($sformatf("tbl%0d_out_valid", r), 32'(bus.out_valid), 32'(tbl[r].ov));
         chk($sformatf("tbl%0d_out_data", r), 32'(bus.out_data), 32'(tbl[r].od));
         tick();
      end

      // Burst lock: req 1 sends last=0,0,1 while 0 and 2 contend
      lock_v    = '{4'b0010, 4'b0111, 4'b0111, 4'b0111};
      lock_last = '{4'b1101, 4'b1101, 4'b1111, 4'b1111};
      if (LOCK) lock_exp = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
      else      lock_exp = '{4'b0010, 4'b0100, 4'b0001, 4'b0010};
      apply(1'b1, 4'h0, 4'hF, 1'b1);
      tick();
      for (int b = 0; b < 4; b++) begin
         apply(1'b0, lock_v[b], lock_last[b], 1'b1);
         chk($sformatf("lock_grant%0d", b), 32'(bus.grant), 32'(lock_exp[b]));
         check_model();
         tick();
      end

      // Reset while a burst is locked and the output is full
      apply(1'b1, 4'h0, 4'hF, 1'b1);
      tick();
      apply(1'b0, 4'b0010, 4'b1101, 1'b1);
      tick();
      apply(1'b1, 4'hF, 4'hF, 1'b1);
      chk("rstlock_out_valid_before", 32'(bus.out_valid), 32'd1);
      chk("rstlock_req_ready_in_rst", 32'(bus.req_ready), 32'd0);
      tick();
      apply(1'b0, 4'hF, 4'hF, 1'b1);
      chk("rstlock_out_valid_after", 32'(bus.out_valid), 32'd0);
      chk("rstlock_grant_after", 32'(bus.grant), 32'h1);
      check_model();
      tick();

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         bus.req_data = $urandom;
         apply(($urandom_range(0, 63) == 0), 4'($urandom), 4'($urandom | $urandom),
               ($urandom_range(0, 3) != 0));
         check_model();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
